reg_fetch_stage: RTL
====================

Name: reg_fetch_stage

Overview:
- Pipeline stage 2 (Register Fetch) of the 5-stage single-thread core. Sits between instruction decode and execute.
- Accepts one decoded instruction at a time and checks the register-file busy scoreboard for source hazards, stalling until sources are clear.
- Reads source operands (with writeback forwarding), marks the destination busy, and presents an operand bundle to execute with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, register data width
- RADDR_W, 5, register address width (32 architectural names: 0=zero, 1..29 GPR, 30=lo, 31=hi)
- STATE_W, 3, scoreboard count width per register
- STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (branch/exception)
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage can accept this cycle
- dec_rs, dec_rt, dec_rd  in  RADDR_W each  source/destination register numbers
- dec_use_rs, dec_use_rt, dec_rd_we  in  1 each  operand-use and destination-write flags
- dec_ctrl  in  32  opaque control/immediate bundle, passed through
- rf_rs_addr, rf_rt_addr  out  RADDR_W  register file read addresses
- rf_rs_data, rf_rt_data  in  XLEN  combinational read data
- rf_rs_state, rf_rt_state  in  STATE_W  scoreboard count for each source
- rf_set_busy  out  1  one-cycle pulse: increment scoreboard of rf_busy_addr
- rf_release  out  1  one-cycle pulse: decrement scoreboard of rf_busy_addr (flush of an issued instruction)
- rf_busy_addr  out  RADDR_W  target of set/release
- wb_valid  in  1  writeback writing this cycle
- wb_addr  in  RADDR_W  writeback register
- wb_data  in  XLEN  writeback data
- ex_valid  out  1  operand bundle valid
- ex_ready  in  1  execute accepts
- ex_rs_val, ex_rt_val  out  XLEN  operands
- ex_rd, ex_rd_we, ex_ctrl  out  RADDR_W/1/32  forwarded destination and control
- stall_cycles  out  STALL_CNT_W  saturating count of cycles spent in WAIT with a hazard

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset: state=EMPTY; ex_valid=0; dec_ready=1; rf_set_busy=0; rf_release=0; all data outputs 0; stall_cycles=0.
- FSM states:
  - EMPTY: dec_ready=1. On dec_valid, latch the instruction into the hold register and go to WAIT.
  - WAIT: dec_ready=0. rf_*_addr are driven from the hold register. A source is ready if any of:
    - its use flag is 0;
    - its address is 0, 30 or 31;
    - its state==0;
    - its state==1 and wb_valid and wb_addr matches it (forward wb_data).
  - WAIT with both sources ready: at the clock edge, register the operands into the ex_* outputs (forwarded value has priority over rf data) and go to FULL.
    - In that same cycle, drive rf_set_busy=1 with rf_busy_addr=rd, only if rd_we and rd is in 1..29.
  - WAIT with a hazard: stall_cycles increments (saturates at all-ones).
  - FULL: ex_valid=1. On ex_ready with dec_valid, latch the new instruction and go to WAIT. On ex_ready without dec_valid, go to EMPTY.
    - dec_ready = ex_ready in FULL.
- Latency: instruction accepted at edge N, no hazard → ex_valid=1 after edge N+1. Each hazard cycle adds 1.
- The scoreboard check precedes set_busy, so rd==rs in the same instruction does not self-stall.
- The rd is marked busy exactly once per issued instruction. set_busy is never asserted in EMPTY or FULL.
- Flush (highest priority):
  - In WAIT: drop the instruction; no set_busy is issued that cycle.
  - In FULL: drop the instruction; pulse rf_release with rf_busy_addr=ex_rd if ex_rd_we and ex_rd is in 1..29.
  - In all cases: next state EMPTY; ex_valid=0 the next cycle; dec_valid ignored that cycle.
- Reset mid-operation: the scoreboard is reset by its owner. This stage emits no release on reset.
- ex_* outputs hold stable while ex_valid=1 and ex_ready=0.

Decomposition:
- Shared package rf_pkg:
  - state enum {EMPTY, WAIT, FULL};
  - constants REG_ZERO=0, REG_LO=30, REG_HI=31, FIRST_TRACKED=1, LAST_TRACKED=29;
  - packed struct for the decode bundle (rs, rt, rd, use flags, rd_we, ctrl).
- One sub-module, src_hazard_check: per-source combinational ready and forwarded-value select. Instantiated twice (rs, rt).

Test Plan:
- Independent instruction: rs=3, rt=4, both state=0, rf data 0x11/0x22, ex_ready=1 → ex_valid the cycle after accept with 0x11/0x22; rf_set_busy pulse with rf_busy_addr=rd=5.
- RAW stall: rs=5, rf_rs_state=1 for 3 cycles, then wb_valid with wb_addr=5 and wb_data=0xDEAD → issue on the wb cycle with ex_rs_val=0xDEAD; stall_cycles=3.
- Special registers: rs=0, rt=31 with states forced nonzero → no stall; rd=30 with rd_we=1 → no rf_set_busy.
- Backpressure: ex_ready=0 for 4 cycles in FULL → ex_* stable, dec_ready=0. When ex_ready rises with dec_valid=1 → next instruction accepted the same edge.
- Flush in FULL: issued instruction with rd=7, then flush → rf_release pulse with addr 7; ex_valid=0 next cycle; state EMPTY.
- Async reset asserted in WAIT mid-hazard → all outputs reset immediately; after release, dec_ready=1 and stall_cycles=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register fetch stage.
package rf_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RADDR_W     = 5;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned CTRL_W      = 32;

  localparam logic [RADDR_W-1:0] REG_ZERO      = RADDR_W'(0);
  localparam logic [RADDR_W-1:0] REG_LO        = RADDR_W'(30);
  localparam logic [RADDR_W-1:0] REG_HI        = RADDR_W'(31);
  localparam logic [RADDR_W-1:0] FIRST_TRACKED = RADDR_W'(1);
  localparam logic [RADDR_W-1:0] LAST_TRACKED  = RADDR_W'(29);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Decoded instruction as accepted from decode
  typedef struct packed {
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    logic               use_rs;
    logic               use_rt;
    logic               rd_we;
    logic [CTRL_W-1:0]  ctrl;
  } dec_bundle_t;

  // Registers whose busy state lives in the scoreboard
  function automatic logic is_tracked(input logic [RADDR_W-1:0] r);
    return (r >= FIRST_TRACKED) && (r <= LAST_TRACKED);
  endfunction

  // Sources that never stall (zero, lo, hi)
  function automatic logic is_untracked_src(input logic [RADDR_W-1:0] r);
    return (r == REG_ZERO) || (r == REG_LO) || (r == REG_HI);
  endfunction

endpackage

// File: rtl/src_hazard_check.sv
// Per-source readiness and operand select with writeback forwarding.
module src_hazard_check
  import rf_pkg::*;
(
  input  logic               use_src,
  input  logic [RADDR_W-1:0] addr,
  input  logic [STATE_W-1:0] state,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               ready_c,
  output logic [XLEN-1:0]    val_c
);

  logic fwd_hit;

  // Register zero is hardwired, so a writeback naming it is never forwarded
  assign fwd_hit = wb_valid && (wb_addr == addr) && (addr != REG_ZERO);

  // Ready when unused, untracked, idle, or its sole pending writer lands now
  always_comb begin
    ready_c = 1'b0;
    if (!use_src || is_untracked_src(addr) || (state == '0)) begin
      ready_c = 1'b1;
    end else if ((state == STATE_W'(1)) && fwd_hit) begin
      ready_c = 1'b1;
    end
  end

  // Forwarded writeback data wins over the register file read
  assign val_c = fwd_hit ? wb_data : rf_data;

endmodule

// File: rtl/reg_fetch_stage.sv
// Register fetch stage: hazard check, operand read/forward, destination busy marking.
module reg_fetch_stage
  import rf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [RADDR_W-1:0]     dec_rs,
  input  logic [RADDR_W-1:0]     dec_rt,
  input  logic [RADDR_W-1:0]     dec_rd,
  input  logic                   dec_use_rs,
  input  logic                   dec_use_rt,
  input  logic                   dec_rd_we,
  input  logic [CTRL_W-1:0]      dec_ctrl,
  output logic [RADDR_W-1:0]     rf_rs_addr,
  output logic [RADDR_W-1:0]     rf_rt_addr,
  input  logic [XLEN-1:0]        rf_rs_data,
  input  logic [XLEN-1:0]        rf_rt_data,
  input  logic [STATE_W-1:0]     rf_rs_state,
  input  logic [STATE_W-1:0]     rf_rt_state,
  output logic                   rf_set_busy,
  output logic                   rf_release,
  output logic [RADDR_W-1:0]     rf_busy_addr,
  input  logic                   wb_valid,
  input  logic [RADDR_W-1:0]     wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        ex_rs_val,
  output logic [XLEN-1:0]        ex_rt_val,
  output logic [RADDR_W-1:0]     ex_rd,
  output logic                   ex_rd_we,
  output logic [CTRL_W-1:0]      ex_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e      state_q;
  state_e      state_d;
  dec_bundle_t hold_q;
  dec_bundle_t dec_in;

  logic            rs_ready_c;
  logic            rt_ready_c;
  logic [XLEN-1:0] rs_val_c;
  logic [XLEN-1:0] rt_val_c;
  logic            srcs_ready_c;
  logic            issue_c;
  logic            accept_c;

  assign dec_in = '{rs: dec_rs, rt: dec_rt, rd: dec_rd, use_rs: dec_use_rs,
                    use_rt: dec_use_rt, rd_we: dec_rd_we, ctrl: dec_ctrl};

  // Read addresses always come from the held instruction
  assign rf_rs_addr = hold_q.rs;
  assign rf_rt_addr = hold_q.rt;

  src_hazard_check u_rs_check (
    .use_src  (hold_q.use_rs),
    .addr     (hold_q.rs),
    .state    (rf_rs_state),
    .rf_data  (rf_rs_data),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ready_c  (rs_ready_c),
    .val_c    (rs_val_c)
  );

  src_hazard_check u_rt_check (
    .use_src  (hold_q.use_rt),
    .addr     (hold_q.rt),
    .state    (rf_rt_state),
    .rf_data  (rf_rt_data),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ready_c  (rt_ready_c),
    .val_c    (rt_val_c)
  );

  assign srcs_ready_c = rs_ready_c && rt_ready_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (dec_valid) state_d = WAIT;
        WAIT:  if (srcs_ready_c) state_d = FULL;
        FULL:  if (ex_ready) state_d = dec_valid ? WAIT : EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake and scoreboard pulses per state
  always_comb begin
    dec_ready    = 1'b0;
    issue_c      = 1'b0;
    rf_set_busy  = 1'b0;
    rf_release   = 1'b0;
    rf_busy_addr = '0;
    unique case (state_q)
      EMPTY: dec_ready = !flush;
      WAIT: begin
        issue_c     = !flush && srcs_ready_c;
        rf_set_busy = issue_c && hold_q.rd_we && is_tracked(hold_q.rd);
        if (rf_set_busy) rf_busy_addr = hold_q.rd;
      end
      FULL: begin
        dec_ready  = !flush && ex_ready;
        rf_release = flush && ex_rd_we && is_tracked(ex_rd);
        if (rf_release) rf_busy_addr = ex_rd;
      end
      default: dec_ready = 1'b0;
    endcase
    accept_c = dec_ready && dec_valid;
  end

  // Hold register, execute bundle and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      ex_valid  <= 1'b0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_rd     <= '0;
      ex_rd_we  <= 1'b0;
      ex_ctrl   <= '0;
    end else begin
      ex_valid <= (state_d == FULL);
      if (accept_c) begin
        hold_q <= dec_in;
      end
      if (issue_c) begin
        ex_rs_val <= rs_val_c;
        ex_rt_val <= rt_val_c;
        ex_rd     <= hold_q.rd;
        ex_rd_we  <= hold_q.rd_we;
        ex_ctrl   <= hold_q.ctrl;
      end
    end
  end

  // Saturating count of hazard cycles spent waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state_q == WAIT) && !srcs_ready_c && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule
